// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw mechanical push-button pin into clean events.
// The pin is double-flop synchronised and polarity-normalised, then qualified by
// a four-state debounce FSM. A hold counter produces one long-press event per press.
//
// Ports:
//   clk            system clock, all logic on its rising edge
//   rst            synchronous active-high reset
//   btn_in         raw asynchronous button pin
//   btn_level      debounced button state, 1 = pressed
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   long_pulse     one-cycle pulse, once per press, after LONG_PRESS_CYCLES of hold
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 270000,
    parameter int unsigned LONG_PRESS_CYCLES = 27000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // Pin level when the button is not pressed.
    localparam logic IDLE_PIN = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic              sync1;
    logic              sync2;
    logic              raw_s;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              long_done;
    logic              long_done_nxt;
    logic              long_fire_c;

    logic              btn_level_nxt;
    logic              press_nxt;
    logic              release_nxt;
    logic              long_nxt;

    // Two-flop synchroniser, reset to the unpressed pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Normalised synchronised level: 1 = pressed.
    assign raw_s = sync2 ^ IDLE_PIN;

    // State register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            long_done     <= long_done_nxt;
            btn_level     <= btn_level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    // Next-state, debounce counter and hold counter logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hold_cnt_nxt  = hold_cnt;
        long_done_nxt = long_done;
        long_fire_c   = 1'b0;

        case (state)
            IDLE: begin
                if (raw_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!raw_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (raw_s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Hold counter runs across release bounces and saturates at its limit.
        if (state == HELD || state == RELEASE_WAIT) begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
            // An accepted release on the same edge takes precedence.
            if (hold_cnt == HOLD_MAX && !long_done && state_nxt != IDLE) begin
                long_fire_c   = 1'b1;
                long_done_nxt = 1'b1;
            end
        end

        // Fresh press restarts the long-press timing.
        if (state == PRESS_WAIT && state_nxt == HELD) begin
            hold_cnt_nxt  = '0;
            long_done_nxt = 1'b0;
        end
    end

    // Output decode, registered in the state register block.
    always_comb begin
        btn_level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
        press_nxt     = (state == PRESS_WAIT) && (state_nxt == HELD);
        release_nxt   = (state == RELEASE_WAIT) && (state_nxt == IDLE);
        long_nxt      = long_fire_c;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10,
// ACTIVE_LOW=1. Each table row is one clock edge: inputs applied before the
// edge, outputs compared just after it.
module tb_btn_debounce;

    typedef struct {
        logic rst;
        logic btn;
        logic lvl;
        logic prs;
        logic rel;
        logic lng;
    } vec_t;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int   n_vec;
    int   n_bad;
    vec_t vq[$];

    btn_debounce #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append n identical rows.
    task automatic add(input int n, input logic r, input logic b, input logic l,
                       input logic p, input logic rl, input logic lg);
        vec_t v;
        v.rst = r; v.btn = b; v.lvl = l; v.prs = p; v.rel = rl; v.lng = lg;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got lvl/prs/rel/lng=%b expected %b", name, act, exp);
        end
    endtask

    // Counts edges until press or release pulse, bounded.
    task automatic wait_pulse(input bit want_release, input int limit, output int lat);
        lat = -1;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if ((want_release ? release_pulse : press_pulse) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        btn_in = 1'b1;

        // Reset with pin pressed, then press detected from the first non-reset edge.
        add(3, 1, 0, 0, 0, 0, 0);
        add(6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(6, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(4, 0, 1, 0, 0, 0, 0);
        // Clean press, long press at 16, release sampled at 30.
        add(6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(9, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 1);
        add(13, 0, 0, 1, 0, 0, 0);
        add(6, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(4, 0, 1, 0, 0, 0, 0);
        // Press bounce at edge 3, press accepted at 10.
        add(3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(6, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(4, 0, 1, 0, 0, 0, 0);
        // Short press: no long pulse.
        add(6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(6, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(6, 0, 1, 0, 0, 0, 0);
        // Release bounce at edges 8-9: level holds, long still at 16.
        add(6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(2, 0, 1, 1, 0, 0, 0);
        add(6, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 1);
        add(3, 0, 0, 1, 0, 0, 0);
        add(6, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(4, 0, 1, 0, 0, 0, 0);
        // Release completes on the long-press edge: release wins.
        add(6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(3, 0, 0, 1, 0, 0, 0);
        add(6, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(12, 0, 1, 0, 0, 0, 0);

        foreach (vq[i]) begin
            rst    = vq[i].rst;
            btn_in = vq[i].btn;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {btn_level, press_pulse, release_pulse, long_pulse},
                  {vq[i].lvl, vq[i].prs, vq[i].rel, vq[i].lng});
        end

        // Reset while held: outputs clear, no release, fresh full-latency press.
        btn_in = 1'b0;
        wait_pulse(1'b0, 20, lat);
        check("held_press_latency", 4'(lat), 4'd6);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 4'b0000);
        rst = 1'b0;
        wait_pulse(1'b0, 20, lat);
        check("post_reset_press_latency", 4'(lat), 4'd6);
        check("post_reset_level", {btn_level, press_pulse, release_pulse, long_pulse}, 4'b1100);
        btn_in = 1'b1;
        wait_pulse(1'b1, 20, lat);
        check("post_reset_release_latency", 4'(lat), 4'd6);
        check("post_reset_release_level", {btn_level, press_pulse, release_pulse, long_pulse}, 4'b0010);
        @(posedge clk); #1;
        check("release_one_cycle", {btn_level, press_pulse, release_pulse, long_pulse}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and conditions one raw mechanical push-button input for the LED shift-register sampler and any other logic that needs clean button events. The raw pin is double-flop synchronised and polarity-normalised, then qualified by a four-state debounce FSM. Outputs are a stable pressed level and single-cycle press, release and long-press event pulses. It sits between the board button pin and the sampling logic, which consumes `btn_level` or `press_pulse` in place of the raw pin.

## Interface
- `DEBOUNCE_CYCLES`, 270000: cycles the synchronised input must stay unchanged to accept a transition (10 ms at 27 MHz); legal range ≥ 2.
- `LONG_PRESS_CYCLES`, 27000000: cycles after `press_pulse` before `long_pulse` fires (1 s at 27 MHz); legal range ≥ 1.
- `ACTIVE_LOW`, 1: 1 means the button pin reads 0 when pressed; 0 means it reads 1 when pressed.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `btn_in` in 1: raw asynchronous button pin.
- `btn_level` out 1: debounced state, 1 = pressed.
- `press_pulse` out 1: one-cycle pulse on an accepted press.
- `release_pulse` out 1: one-cycle pulse on an accepted release.
- `long_pulse` out 1: one-cycle pulse, at most once per press, when the hold reaches `LONG_PRESS_CYCLES`.

## Operation
- Synchroniser: two flops on `btn_in`, inverted when `ACTIVE_LOW`=1, giving `raw_s` (1 = pressed).
- Debounce counter `cnt` must be wide enough for `DEBOUNCE_CYCLES-1`. Hold counter `hold_cnt` must be wide enough for `LONG_PRESS_CYCLES-1` and saturates.
- FSM states:
  - IDLE
    - `raw_s`=1: go to PRESS_WAIT, `cnt`←0.
  - PRESS_WAIT
    - `raw_s`=0: go to IDLE (bounce rejected, no output).
    - `raw_s`=1 and `cnt`==`DEBOUNCE_CYCLES-1`: go to HELD. Set `btn_level`←1 and `press_pulse`←1. Clear `hold_cnt` and `long_done`.
    - Otherwise: `cnt`++.
  - HELD
    - `raw_s`=0: go to RELEASE_WAIT, `cnt`←0.
  - RELEASE_WAIT
    - `raw_s`=1: return to HELD (bounce rejected, `btn_level` stays 1).
    - `raw_s`=0 and `cnt`==`DEBOUNCE_CYCLES-1`: go to IDLE. Set `btn_level`←0 and `release_pulse`←1.
    - Otherwise: `cnt`++.
- Long press:
  - `hold_cnt` increments every cycle in HELD or RELEASE_WAIT until it reaches `LONG_PRESS_CYCLES-1`.
  - At that edge, if `long_done`=0 and the FSM is not exiting to IDLE: `long_pulse`←1 and `long_done`←1.
  - `hold_cnt` is not cleared by a rejected release bounce.
- Simultaneous events:
  - A release completing on the same edge `long_pulse` would fire: the release wins and `long_pulse` is suppressed.
  - Press, release and long pulses are never high together.
- All outputs are registered.

## Timing
- Reset value (`rst` high at an edge):
  - FSM in IDLE, all counters and `long_done` at 0.
  - All four outputs at 0.
  - Synchroniser flops at the unpressed pin level.
- Reset mid-operation: outputs drop to 0 at the next edge and no `release_pulse` is generated. After reset deasserts, a button still held is detected as a fresh press with full latency.
- Press latency:
  - Edge e is the first edge sampling `btn_in` at the pressed level, with the button held steady from then on.
  - `press_pulse` and `btn_level` rise at edge e + `DEBOUNCE_CYCLES` + 2.
- Release latency: symmetric; `release_pulse` rises and `btn_level` falls at edge e' + `DEBOUNCE_CYCLES` + 2.
- `long_pulse` rises exactly `LONG_PRESS_CYCLES` edges after `press_pulse` rises, if the press is still accepted at that edge.
- Every pulse is high for exactly one cycle.
- A bounce of any length shorter than `DEBOUNCE_CYCLES` restarts qualification from IDLE or HELD.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=10, `ACTIVE_LOW`=1.
- Reset: hold `rst`=1 for 3 edges with `btn_in`=0. All outputs read 0 throughout. After `rst` falls at edge r, `press_pulse` rises at edge r+6.
- Clean press: `btn_in` 1→0 sampled at edge 0 and held. `press_pulse`=1 only in the cycle after edge 6. `btn_level`=1 from edge 6.
- Press bounce: `btn_in`=0 at edges 0–2, 1 at edge 3, 0 from edge 4. Exactly one `press_pulse`, at edge 10; nothing earlier.
- Long press: press sampled at edge 0, held; released at edge 30.
  - `press_pulse` at edge 6.
  - Single `long_pulse` at edge 16.
  - `release_pulse` and `btn_level` fall at edge 36.
- Short press: press sampled at edge 0, released at edge 8.
  - `press_pulse` at edge 6, `release_pulse` at edge 14.
  - No `long_pulse`.
- Release bounce: held button gives `btn_in`=1 for 2 edges, then 0 again. No `release_pulse`, `btn_level` stays 1, and `long_pulse` timing is unchanged.
